// File: rtl/ahb_mem_slave_pkg.sv
// Shared AHB-Lite encodings plus the memory slave's FSM state type and lane helpers.
package ahb_mem_slave_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE    = 2'b00,
        TRANS_BUSY    = 2'b01,
        TRANS_NON_SEQ = 2'b10,
        TRANS_SEQ     = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } hsize_t;

    localparam logic HRESP_OKAY    = 1'b0;
    localparam logic HRESP_ERROR   = 1'b1;
    localparam int   NUM_OF_SLAVES = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } mem_slave_state_t;

    function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] lsb);
        logic [3:0] be;
        case (size)
            3'd0:    be = 4'b0001 << lsb;
            3'd1:    be = lsb[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ahb_mem_slave_array.sv
// Word-organised RAM with per-byte write enables and a combinational read port.
module ahb_mem_array #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [3:0]    wbe_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (wbe_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: window decode, wait-state/error FSM, read-only header
// protection and write-to-read forwarding around a byte-enabled word RAM.
//
// state | meaning
// IDLE  | ready, OKAY; completing cycle of any pending legal data phase
// WAIT  | inserting wait states for a legal transfer
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high, new address phase accepted
module ahb_mem_slave
    import ahb_mem_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_BYTES   = 1024,
    parameter int          RO_BYTES    = 4,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int AW    = $clog2(WORDS);

    typedef struct packed {
        logic          valid;
        logic          write;
        logic [AW-1:0] addr;
        logic [3:0]    be;
    } dphase_t;

    mem_slave_state_t state_q, state_d;
    logic [1:0]       wait_cnt_q, wait_cnt_d;
    dphase_t          dp_q;
    logic [31:0]      rdata_q;

    logic [31:0]   offset;
    logic [AW-1:0] a_word;
    logic          active, accept;
    logic          in_range, size_ok, aligned, ro_hit, legal;
    logic          complete_wr;
    logic [3:0]    ram_wbe;
    logic [31:0]   ram_rdata, rd_fwd;
    logic          unused_hburst;

    assign unused_hburst = ^HBURST;

    assign offset = HADDR - BASE_ADDR;
    assign a_word = offset[AW+1:2];

    assign active = HSEL && HREADY &&
                    (HTRANS == TRANS_NON_SEQ || HTRANS == TRANS_SEQ);
    // While the slave is stalling, held address-phase inputs must not be taken.
    assign accept = active && HREADYOUT;

    assign in_range = offset < 32'(MEM_BYTES);
    assign size_ok  = HSIZE <= SIZE_WORD;
    always_comb begin
        aligned = 1'b1;
        if (HSIZE == SIZE_HALF) aligned = !offset[0];
        if (HSIZE == SIZE_WORD) aligned = (offset[1:0] == 2'b00);
    end
    assign ro_hit = HWRITE && (offset < 32'(RO_BYTES));
    assign legal  = in_range && size_ok && aligned && !ro_hit;

    assign complete_wr = (state_q == ST_IDLE) && dp_q.valid && dp_q.write;
    assign ram_wbe     = (complete_wr && !reset) ? dp_q.be : 4'b0000;

    ahb_mem_array #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_mem (
        .clk_i   (HCLK),
        .waddr_i (dp_q.addr),
        .wbe_i   (ram_wbe),
        .wdata_i (HWDATA),
        .raddr_i (a_word),
        .rdata_o (ram_rdata)
    );

    // The RAM write lands on the same edge the read is captured, so merge it here.
    assign rd_fwd = (complete_wr && dp_q.addr == a_word) ?
                    lane_merge(ram_rdata, HWDATA, dp_q.be) : ram_rdata;

    always_ff @(posedge HCLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = 2'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (reset) begin
            dp_q    <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            dp_q.valid <= legal;
            dp_q.write <= HWRITE;
            dp_q.addr  <= a_word;
            dp_q.be    <= lane_enable(HSIZE, offset[1:0]);
            rdata_q    <= (legal && !HWRITE) ? rd_fwd : 32'h0;
        end else if (HREADYOUT) begin
            dp_q    <= '0;
            rdata_q <= '0;
        end
    end

    assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: one zero-wait and one two-wait instance.
module tb_ahb_mem_slave;

    logic        HCLK;
    logic        reset;
    logic        hsel0, hsel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        rdy0, resp0, rdy2, resp2;
    logic [31:0] rdata0, rdata2;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_mem_slave #(.WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahb_mem_slave #(.WAIT_STATES(2)) dut2 (
        .HCLK(HCLK), .reset(reset), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(rdy2), .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rdata2)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr(input logic to2, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] a);
        hsel0  = !to2;
        hsel2  = to2;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic idle();
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd0;
        haddr  = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        hburst = 3'd0;
        hwdata = 32'h0;
        cyc();
        cyc();
        n_checks++;
        if ({rdy0, resp0, rdata0} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_dut0 got rdy=%b resp=%b rdata=%h exp 1 0 0", rdy0, resp0, rdata0);
        end
        n_checks++;
        if ({rdy2, resp2, rdata2} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_dut2 got rdy=%b resp=%b rdata=%h exp 1 0 0", rdy2, resp2, rdata2);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_write_read();
        addr(0, 2'b10, 1, 3'd2, 32'h10);
        cyc();
        hwdata = 32'h1234_5678;
        addr(0, 2'b10, 0, 3'd2, 32'h10);
        n_checks++;
        if ({rdy0, resp0} !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_dphase got rdy=%b resp=%b exp 1 0", rdy0, resp0);
        end
        cyc();
        idle();
        n_checks++;
        if ({rdy0, resp0, rdata0} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL rd_after_wr got rdy=%b resp=%b rdata=%h exp 1 0 12345678", rdy0, resp0, rdata0);
        end
        cyc();
        addr(0, 2'b10, 1, 3'd1, 32'h12);
        cyc();
        hwdata = 32'hBEEF_0000;
        idle();
        cyc();
        addr(0, 2'b10, 0, 3'd2, 32'h10);
        cyc();
        idle();
        n_checks++;
        if (rdata0 !== 32'hBEEF_5678) begin
            n_fail++;
            $display("FAIL half_lane got rdata=%h exp beef5678", rdata0);
        end
        cyc();
    endtask

    task automatic test_ro_error();
        logic [31:0] orig;
        addr(0, 2'b10, 0, 3'd2, 32'h0);
        cyc();
        idle();
        orig = rdata0;
        n_checks++;
        if ({rdy0, resp0} !== 2'b10) begin
            n_fail++;
            $display("FAIL ro_pre_read got rdy=%b resp=%b exp 1 0", rdy0, resp0);
        end
        cyc();
        addr(0, 2'b10, 1, 3'd1, 32'h2);
        cyc();
        idle();
        hwdata = 32'hDEAD_BEEF;
        n_checks++;
        if ({rdy0, resp0} !== 2'b01) begin
            n_fail++;
            $display("FAIL ro_err1 got rdy=%b resp=%b exp 0 1", rdy0, resp0);
        end
        cyc();
        n_checks++;
        if ({rdy0, resp0} !== 2'b11) begin
            n_fail++;
            $display("FAIL ro_err2 got rdy=%b resp=%b exp 1 1", rdy0, resp0);
        end
        cyc();
        n_checks++;
        if ({rdy0, resp0} !== 2'b10) begin
            n_fail++;
            $display("FAIL ro_after got rdy=%b resp=%b exp 1 0", rdy0, resp0);
        end
        addr(0, 2'b10, 0, 3'd2, 32'h0);
        cyc();
        idle();
        n_checks++;
        if (rdata0 !== orig || rdata0[31:16] === 16'hDEAD) begin
            n_fail++;
            $display("FAIL ro_preserved got rdata=%h exp %h", rdata0, orig);
        end
        cyc();
    endtask

    task automatic test_illegal();
        logic [35:0] vec [6];
        vec[0] = {1'b0, 3'd2, 32'h400};
        vec[1] = {1'b0, 3'd2, 32'h12};
        vec[2] = {1'b0, 3'd1, 32'h11};
        vec[3] = {1'b0, 3'd3, 32'h10};
        vec[4] = {1'b1, 3'd0, 32'h3};
        vec[5] = {1'b1, 3'd2, 32'h800};
        for (int i = 0; i < 6; i++) begin
            addr(0, 2'b10, vec[i][35], vec[i][34:32], vec[i][31:0]);
            cyc();
            idle();
            n_checks++;
            if ({rdy0, resp0, rdata0} !== {1'b0, 1'b1, 32'h0}) begin
                n_fail++;
                $display("FAIL illegal%0d_err1 got rdy=%b resp=%b rdata=%h exp 0 1 0", i, rdy0, resp0, rdata0);
            end
            cyc();
            n_checks++;
            if ({rdy0, resp0, rdata0} !== {1'b1, 1'b1, 32'h0}) begin
                n_fail++;
                $display("FAIL illegal%0d_err2 got rdy=%b resp=%b rdata=%h exp 1 1 0", i, rdy0, resp0, rdata0);
            end
            // new transfer issued during the second ERROR cycle
            addr(0, 2'b10, 0, 3'd2, 32'h10);
            cyc();
            idle();
            n_checks++;
            if ({rdy0, resp0, rdata0} !== {1'b1, 1'b0, 32'hBEEF_5678}) begin
                n_fail++;
                $display("FAIL illegal%0d_next got rdy=%b resp=%b rdata=%h exp 1 0 beef5678", i, rdy0, resp0, rdata0);
            end
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [4];
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
        hburst = 3'd3;
        addr(0, 2'b10, 1, 3'd2, 32'h20);
        cyc();
        for (int i = 0; i < 4; i++) begin
            hwdata = wd[i];
            if (i < 3) addr(0, 2'b11, 1, 3'd2, 32'h24 + 32'(4 * i));
            else       addr(0, 2'b10, 0, 3'd2, 32'h2C);
            n_checks++;
            if ({rdy0, resp0} !== 2'b10) begin
                n_fail++;
                $display("FAIL burst_wr%0d got rdy=%b resp=%b exp 1 0", i, rdy0, resp0);
            end
            cyc();
        end
        hburst = 3'd0;
        addr(0, 2'b10, 0, 3'd2, 32'h20);
        n_checks++;
        if ({rdy0, resp0, rdata0} !== {1'b1, 1'b0, 32'hD}) begin
            n_fail++;
            $display("FAIL fwd_read got rdy=%b resp=%b rdata=%h exp 1 0 d", rdy0, resp0, rdata0);
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) addr(0, 2'b10, 0, 3'd2, 32'h24 + 32'(4 * i));
            else       idle();
            n_checks++;
            if ({rdy0, rdata0} !== {1'b1, wd[i]}) begin
                n_fail++;
                $display("FAIL burst_rd%0d got rdy=%b rdata=%h exp 1 %h", i, rdy0, rdata0, wd[i]);
            end
            cyc();
        end
    endtask

    task automatic test_wait_states();
        addr(1, 2'b10, 1, 3'd2, 32'h40);
        cyc();
        hwdata = 32'h1122_3344;
        idle();
        cyc();
        cyc();
        n_checks++;
        if ({rdy2, resp2} !== 2'b10) begin
            n_fail++;
            $display("FAIL ws_prewrite_done got rdy=%b resp=%b exp 1 0", rdy2, resp2);
        end
        addr(1, 2'b10, 1, 3'd0, 32'h41);
        cyc();
        hwdata = 32'h0000_EF00;
        addr(1, 2'b10, 0, 3'd2, 32'h40);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rdy2 !== 1'b0) begin
                n_fail++;
                $display("FAIL ws_wr_wait%0d got rdy=%b exp 0", i, rdy2);
            end
            cyc();
        end
        n_checks++;
        if ({rdy2, resp2} !== 2'b10) begin
            n_fail++;
            $display("FAIL ws_wr_done got rdy=%b resp=%b exp 1 0", rdy2, resp2);
        end
        cyc();
        idle();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rdy2 !== 1'b0) begin
                n_fail++;
                $display("FAIL ws_rd_wait%0d got rdy=%b exp 0", i, rdy2);
            end
            cyc();
        end
        n_checks++;
        if ({rdy2, resp2, rdata2} !== {1'b1, 1'b0, 32'h1122_EF44}) begin
            n_fail++;
            $display("FAIL ws_rd_data got rdy=%b resp=%b rdata=%h exp 1 0 1122ef44", rdy2, resp2, rdata2);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        addr(1, 2'b10, 1, 3'd2, 32'h50);
        cyc();
        hwdata = 32'hCAFE_0001;
        idle();
        cyc();
        cyc();
        cyc();
        addr(1, 2'b10, 1, 3'd2, 32'h50);
        cyc();
        hwdata = 32'h0BAD_0BAD;
        idle();
        n_checks++;
        if (rdy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_inwait got rdy=%b exp 0", rdy2);
        end
        reset = 1'b1;
        cyc();
        n_checks++;
        if ({rdy2, resp2, rdata2} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got rdy=%b resp=%b rdata=%h exp 1 0 0", rdy2, resp2, rdata2);
        end
        reset = 1'b0;
        cyc();
        addr(1, 2'b10, 0, 3'd2, 32'h50);
        cyc();
        idle();
        cyc();
        cyc();
        n_checks++;
        if ({rdy2, rdata2} !== {1'b1, 32'hCAFE_0001}) begin
            n_fail++;
            $display("FAIL rst_mid_old_data got rdy=%b rdata=%h exp 1 cafe0001", rdy2, rdata2);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_ro_error();
        test_illegal();
        test_back_to_back();
        test_wait_states();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_mem_slave.md
# ahb_mem_slave

AHB-Lite memory slave that the bus-protocol assertion monitor observes: it decodes one address window, holds a byte-addressable memory, and answers transfers with data, wait states and OKAY/ERROR responses. It is the design under test of the memory-slave VIP and sits on the slave side of the shared AHB interface. It enforces a read-only header region and a two-cycle ERROR response for illegal transfers.

## Interface
- BASE_ADDR, 32'h0000_0000: byte base of this slave's window.
- MEM_BYTES, 1024: window size in bytes; power of two.
- RO_BYTES, 4: bytes at window offsets 0..RO_BYTES-1 are read-only.
- WAIT_STATES, 0: wait cycles inserted per OKAY NON_SEQ/SEQ data phase; range 0..3.
- HCLK  in  1  bus clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE/BUSY/NON_SEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 byte, 1 half, 2 word; others illegal.
- HBURST  in  3  burst type; informational only, no decode effect.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-wide ready; address phase sampled only when high.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data, little-endian lanes.

## Operation
- Active transfer: HSEL & HREADY & HTRANS in {NON_SEQ, SEQ} at a rising edge; its control is registered for the data phase.
- IDLE/BUSY or unselected: next data phase is zero-wait OKAY.
- ERROR when any hold: offset = HADDR-BASE_ADDR >= MEM_BYTES; HSIZE > 2; misaligned (half with HADDR[0]=1, word with HADDR[1:0]!=0); write with offset < RO_BYTES.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. Active legal transfer -> WAIT if WAIT_STATES>0, else stay IDLE (completes next cycle). Active illegal -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0; counter counts WAIT_STATES cycles then returns to IDLE for the completing cycle.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2. ERR2: HREADYOUT=1, HRESP=1; a new active transfer sampled here is decoded as from IDLE.
- Writes commit byte lanes per HSIZE/HADDR[1:0] in the completing data-phase cycle; errored writes never modify memory.
- Reads return the addressed word; unaddressed lanes are don't-care; errored reads drive HRDATA=0.
- Read at address phase colliding with a write in its data phase to the same word: forward written lanes (read-after-write returns new data).
- Memory contents are not cleared by reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, registered control cleared.
- Reset mid-transfer (including WAIT/ERR1): aborts; pending write is dropped; outputs reset next edge.
- OKAY latency: data phase lasts 1+WAIT_STATES cycles; HRDATA valid in final cycle (HREADYOUT=1).
- ERROR: exactly two cycles, HRESP=1 in both; HREADYOUT 0 then 1.
- IDLE address phase -> next cycle HREADYOUT=1, HRESP=0 guaranteed.
- Back-to-back bursts: SEQ beats pipeline with zero bubbles when WAIT_STATES=0.
- Address-phase inputs held while HREADYOUT=0 are ignored until the completing cycle.

## Structure
- definesPkg holds htrans_t (IDLE, BUSY, NON_SEQ, SEQ), hburst_t, hsize_t, HRESP_OKAY/HRESP_ERROR, NUM_OF_SLAVES; this block adds its FSM state enum there.
- Sub-module ahb_mem_array: MEM_BYTES/4 x 32 word RAM, 4-bit byte-enable write, async read; the slave owns decode, FSM, forwarding.

## Test plan
- Word write 0x1234_5678 to offset 0x10, then read -> HRDATA=0x1234_5678, HRESP=0, one-cycle data phases (WAIT_STATES=0).
- Write to offset 0x2 (read-only) -> HRESP=1 for two cycles, HREADYOUT 0 then 1; subsequent read of offset 0 returns original value.
- Read offset 0x400 (MEM_BYTES=1024) -> two-cycle ERROR, HRDATA=0.
- INCR4 write 0xA,0xB,0xC,0xD from 0x20 followed immediately by NON_SEQ read of 0x2C -> read returns 0xD via forwarding.
- WAIT_STATES=2, byte write 0xEF to 0x41 then word read 0x40 -> HREADYOUT low 2 cycles each, HRDATA[15:8]=0xEF.
- Assert reset during WAIT of a write to 0x50 -> outputs at reset values next edge; read of 0x50 shows old contents.
